// File: rtl/clk_strobe_gen.sv
// clk_strobe_gen: NCO clock-enable generator with warm-up hold-off; define CLK_STROBE_GEN_CNT_EN to add the stb_cnt strobe counter
module clk_strobe_gen #(
  parameter int W      = 32,
  parameter int WARMUP = 1024,
  parameter int CW     = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         phase_clr,
  input  logic [W-1:0] inc_in,
  input  logic         inc_ld,
  output logic [W-1:0] inc_cur,
  output logic         ready,
  output logic         stb,
  output logic         stb_180
`ifdef CLK_STROBE_GEN_CNT_EN
  ,
  output logic [CW-1:0] stb_cnt
`endif
);
  localparam int WCW = $clog2(WARMUP + 1);
  logic [W-1:0]   acc, pend, acc_nxt, inc_nxt, pend_nxt;
  logic [W:0]     sum;
  logic [WCW-1:0] warm_cnt;
  logic           pend_v, pend_v_nxt, add, carry, xfer, stb_nxt, stb_180_nxt;
  // phase add, strobe decode and glitch-free increment hand-off (only at wrap, idle or warm-up)
  always_comb begin
    add         = ready & en & ~phase_clr;
    sum         = {1'b0, acc} + {1'b0, inc_cur};
    carry       = add & sum[W];
    xfer        = ~ready | (inc_cur == '0) | carry;
    stb_nxt     = carry;
    stb_180_nxt = add & ~acc[W-1] & sum[W-1] & ~sum[W];
    acc_nxt     = phase_clr ? '0 : add ? sum[W-1:0] : acc;
    pend_nxt    = inc_ld ? inc_in : pend;
    inc_nxt     = (inc_ld & xfer) ? inc_in : (pend_v & xfer) ? pend : inc_cur;
    pend_v_nxt  = inc_ld ? ~xfer : (pend_v & ~xfer);
  end
  // warm-up counter; ready latches once WARMUP edges have passed since reset release
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      warm_cnt <= '0;
      ready    <= 1'b0;
    end else if (!ready) begin
      warm_cnt <= warm_cnt + 1'b1;
      ready    <= (warm_cnt == WCW'(WARMUP - 1));
    end
  end
  // phase accumulator, increment registers and registered strobes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc     <= '0;
      inc_cur <= '0;
      pend    <= '0;
      pend_v  <= 1'b0;
      stb     <= 1'b0;
      stb_180 <= 1'b0;
    end else begin
      acc     <= acc_nxt;
      inc_cur <= inc_nxt;
      pend    <= pend_nxt;
      pend_v  <= pend_v_nxt;
      stb     <= stb_nxt;
      stb_180 <= stb_180_nxt;
    end
  end
`ifdef CLK_STROBE_GEN_CNT_EN
  // strobe counter advances on the same edge that raises stb
  always_ff @(posedge clk) begin
    if (!rst_n || phase_clr) stb_cnt <= '0;
    else if (stb_nxt) stb_cnt <= stb_cnt + 1'b1;
  end
`else
  logic unused_cw;
  assign unused_cw = ^CW;
`endif
endmodule

// File: tb/tb_clk_strobe_gen.sv
// tb_clk_strobe_gen: scoreboard bench for clk_strobe_gen with W=8, WARMUP=4
module tb_clk_strobe_gen;
  localparam int W = 8;
  localparam int WARMUP = 4;
  localparam int CW = 16;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, phase_clr = 1'b0, inc_ld = 1'b0;
  logic [W-1:0] inc_in = '0;
  logic [W-1:0] inc_cur;
  logic ready, stb, stb_180;
  logic [CW-1:0] stb_cnt_obs;
  typedef struct packed {
    logic r;
    logic s;
    logic h;
    logic [W-1:0] inc;
    logic [CW-1:0] cnt;
  } exp_t;
  exp_t q[$];
  int checks = 0, failures = 0;
  logic [W-1:0] m_acc, m_inc, m_pend;
  logic m_pv, m_stb, m_s180;
  logic [CW-1:0] m_cnt;
  int m_edges;
`ifdef CLK_STROBE_GEN_CNT_EN
  logic [CW-1:0] stb_cnt;
  assign stb_cnt_obs = stb_cnt;
`else
  assign stb_cnt_obs = m_cnt;
`endif
  clk_strobe_gen #(.W(W), .WARMUP(WARMUP), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .phase_clr(phase_clr),
    .inc_in(inc_in), .inc_ld(inc_ld), .inc_cur(inc_cur),
    .ready(ready), .stb(stb), .stb_180(stb_180)
`ifdef CLK_STROBE_GEN_CNT_EN
    , .stb_cnt(stb_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic r, input logic e, input logic c, input logic l, input logic [W-1:0] v);
    exp_t x;
    logic [W:0] s;
    logic add, cy, xf;
    rst_n = r; en = e; phase_clr = c; inc_ld = l; inc_in = v;
    if (!r) begin
      m_acc = '0; m_inc = '0; m_pend = '0; m_pv = 1'b0;
      m_stb = 1'b0; m_s180 = 1'b0; m_cnt = '0; m_edges = 0;
    end else begin
      add = (m_edges >= WARMUP) && e && !c;
      s = {1'b0, m_acc} + {1'b0, m_inc};
      cy = add && s[W];
      xf = (m_edges < WARMUP) || (m_inc == '0) || cy;
      if (l && xf) begin m_inc = v; m_pend = v; m_pv = 1'b0; end
      else if (l) begin m_pend = v; m_pv = 1'b1; end
      else if (m_pv && xf) begin m_inc = m_pend; m_pv = 1'b0; end
      m_stb = cy;
      m_s180 = add && !m_acc[W-1] && s[W-1] && !cy;
      if (c) m_acc = '0;
      else if (add) m_acc = s[W-1:0];
      m_cnt = c ? '0 : m_cnt + CW'(cy);
      if (m_edges < WARMUP) m_edges++;
    end
    x.r = (m_edges >= WARMUP); x.s = m_stb; x.h = m_s180; x.inc = m_inc; x.cnt = m_cnt;
    q.push_back(x);
    @(posedge clk);
    #1;
    if (q.size() == 0) chk("queue_empty", 32'd0, 32'd1);
    else begin
      x = q.pop_front();
      chk("ready", {31'd0, ready}, {31'd0, x.r});
      chk("stb", {31'd0, stb}, {31'd0, x.s});
      chk("stb_180", {31'd0, stb_180}, {31'd0, x.h});
      chk("inc_cur", {24'd0, inc_cur}, {24'd0, x.inc});
`ifdef CLK_STROBE_GEN_CNT_EN
      chk("stb_cnt", {16'd0, stb_cnt_obs}, {16'd0, x.cnt});
`endif
    end
  endtask
  initial begin
    int first_s, first_h, n;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("rst_ready", {31'd0, ready}, 0);
    chk("rst_inc", {24'd0, inc_cur}, 0);
    step(1, 1, 0, 1, 8'h40);
    chk("inc_before_ready", {24'd0, inc_cur}, 32'h40);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    chk("ready_pre", {31'd0, ready}, 0);
    step(1, 1, 0, 0, 0);
    chk("ready_edge4", {31'd0, ready}, 1);
    first_s = -1; first_h = -1; n = 0;
    for (int i = 0; i < 12; i++) begin
      step(1, 1, 0, 0, 0);
      if (stb) begin n++; if (first_s < 0) first_s = i; end
      if (stb_180 && first_h < 0) first_h = i;
    end
    chk("first_stb", first_s, 3);
    chk("first_stb180", first_h, 1);
    chk("p1_count", n, 3);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 1, 8'h80);
    chk("inc_held", {24'd0, inc_cur}, 32'h40);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    chk("inc_switch", {24'd0, inc_cur}, 32'h80);
    chk("switch_stb", {31'd0, stb}, 1);
    n = 0;
    for (int i = 0; i < 8; i++) begin step(1, 1, 0, 0, 0); n += int'(stb); end
    chk("p2_count", n, 4);
    step(1, 1, 0, 1, 8'h55);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    chk("inc_55", {24'd0, inc_cur}, 32'h55);
    n = 0;
    for (int i = 0; i < 259; i++) begin
      step(1, !(i >= 100 && i < 103), 0, 0, 0);
      n += int'(stb);
    end
    chk("count_85", n, 85);
    step(1, 1, 0, 1, 8'hFF);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0);
    chk("inc_ff", {24'd0, inc_cur}, 32'hFF);
    step(1, 1, 1, 0, 0);
    chk("clr_stb", {31'd0, stb}, 0);
    step(1, 1, 0, 0, 0);
    chk("ff_first", {31'd0, stb}, 0);
    step(1, 1, 0, 0, 0);
    chk("ff_second", {31'd0, stb}, 1);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    chk("clr2_stb", {31'd0, stb}, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("mid_rst_ready", {31'd0, ready}, 0);
    chk("mid_rst_stb", {31'd0, stb}, 0);
    chk("mid_rst_inc", {24'd0, inc_cur}, 0);
`ifdef CLK_STROBE_GEN_CNT_EN
    chk("cnt_rst", {16'd0, stb_cnt_obs}, 0);
`endif
    n = 0;
    for (int i = 0; i < 6; i++) begin step(1, 1, 0, 0, 0); n += int'(stb); end
    chk("inc0_nostb", n, 0);
    step(1, 0, 0, 1, 8'hFF);
    chk("idle_xfer", {24'd0, inc_cur}, 32'hFF);
    n = 0;
    for (int i = 0; i < 20 && n < 10; i++) begin step(1, 1, 0, 0, 0); n += int'(stb); end
    chk("ten_pulses", n, 10);
`ifdef CLK_STROBE_GEN_CNT_EN
    chk("cnt_10", {16'd0, stb_cnt_obs}, 10);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
